// File: rtl/soc_rtc_alarm_if.sv
// ============================================================================
// soc_rtc_alarm_if : register bus between a host and the RTC alarm unit
// Revision: 1.0
// ============================================================================
`default_nettype none

interface soc_rtc_alarm_if #(
  parameter int IO_MAP_WIDTH = 32
);
  logic [1:0]              alarm_addr;
  logic [IO_MAP_WIDTH-1:0] alarm_wdata;
  logic                    alarm_we;
  logic                    alarm_re;
  logic [IO_MAP_WIDTH-1:0] alarm_rdata;
  logic                    alarm_ready;
  logic                    alarm_irq;

  modport master (
    output alarm_addr, alarm_wdata, alarm_we, alarm_re,
    input  alarm_rdata, alarm_ready, alarm_irq
  );

  modport slave (
    input  alarm_addr, alarm_wdata, alarm_we, alarm_re,
    output alarm_rdata, alarm_ready, alarm_irq
  );
endinterface

`default_nettype wire

// File: rtl/soc_rtc_alarm.sv
// ============================================================================
// soc_rtc_alarm : wrap-safe compare of the RTC count against a programmable
//                 target, with one-shot/periodic reload and sticky IRQ status
// Revision: 1.0
// ============================================================================
`default_nettype none

module soc_rtc_alarm #(
  parameter int IO_MAP_WIDTH = 32
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic [IO_MAP_WIDTH-1:0] rtc_count,
  input  wire logic                    rtc_valid,
  soc_rtc_alarm_if.slave               bus
);

  localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] c_ADDR_CMP    = 2'd1;
  localparam logic [1:0] c_ADDR_PERIOD = 2'd2;
  localparam logic [1:0] c_ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_en;
  logic                    r_periodic;
  logic                    r_irq_en;
  logic [IO_MAP_WIDTH-1:0] r_cmp;
  logic [IO_MAP_WIDTH-1:0] r_period;
  logic                    r_pend;
  logic                    r_missed;
  logic [IO_MAP_WIDTH-1:0] r_rdata;
  logic                    r_ready;

  logic                    w_rd;
  logic                    w_ctrl_wr;
  logic                    w_cmp_wr;
  logic                    w_period_wr;
  logic                    w_status_wr;
  logic                    w_reached;
  logic                    w_match;
  logic                    w_reload_req;
  logic                    w_en_after_reload;
  logic [IO_MAP_WIDTH-1:0] w_rdata_mux;

  // A write shadows a simultaneous read; the pair still earns one ready.
  assign w_rd        = bus.alarm_re & ~bus.alarm_we;
  assign w_ctrl_wr   = bus.alarm_we & (bus.alarm_addr == c_ADDR_CTRL);
  assign w_cmp_wr    = bus.alarm_we & (bus.alarm_addr == c_ADDR_CMP);
  assign w_period_wr = bus.alarm_we & (bus.alarm_addr == c_ADDR_PERIOD);
  assign w_status_wr = bus.alarm_we & (bus.alarm_addr == c_ADDR_STATUS);

  // Sign of the modular difference: "reached or passed" within half the range.
  assign w_reached    = ($signed(rtc_count - r_cmp) >= 0);
  assign w_match      = (r_state == ST_ARMED) & rtc_valid & w_reached;
  assign w_reload_req = r_periodic & (r_period != '0);

  assign w_en_after_reload = w_ctrl_wr ? bus.alarm_wdata[0] : r_en;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_OFF: begin
        if (w_ctrl_wr && bus.alarm_wdata[0]) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_match)                               w_state_next = w_reload_req ? ST_RELOAD : ST_OFF;
        else if (w_ctrl_wr && !bus.alarm_wdata[0]) w_state_next = ST_OFF;
      end
      ST_RELOAD: begin
        w_state_next = w_en_after_reload ? ST_ARMED : ST_OFF;
      end
      default: w_state_next = ST_OFF;
    endcase
  end

  always_comb begin
    w_rdata_mux = '0;
    case (bus.alarm_addr)
      c_ADDR_CTRL:   w_rdata_mux = {{(IO_MAP_WIDTH-3){1'b0}}, r_irq_en, r_periodic, r_en};
      c_ADDR_CMP:    w_rdata_mux = r_cmp;
      c_ADDR_PERIOD: w_rdata_mux = r_period;
      c_ADDR_STATUS: w_rdata_mux = {{(IO_MAP_WIDTH-2){1'b0}}, r_missed, r_pend};
      default:       w_rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_OFF;
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_irq_en   <= 1'b0;
      r_cmp      <= '0;
      r_period   <= '0;
      r_pend     <= 1'b0;
      r_missed   <= 1'b0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // A one-shot match disarms in hardware and overrides a same-cycle CTRL write.
      if (w_match && !w_reload_req) r_en <= 1'b0;
      else if (w_ctrl_wr)           r_en <= bus.alarm_wdata[0];

      if (w_ctrl_wr) begin
        r_periodic <= bus.alarm_wdata[1];
        r_irq_en   <= bus.alarm_wdata[2];
      end

      if (w_cmp_wr)                   r_cmp <= bus.alarm_wdata;
      else if (r_state == ST_RELOAD)  r_cmp <= r_cmp + r_period;

      if (w_period_wr) r_period <= bus.alarm_wdata;

      if (w_match)                                 r_pend <= 1'b1;
      else if (w_status_wr && bus.alarm_wdata[0])  r_pend <= 1'b0;

      if (w_match && r_pend)                       r_missed <= 1'b1;
      else if (w_status_wr && bus.alarm_wdata[1])  r_missed <= 1'b0;

      r_ready <= bus.alarm_we | bus.alarm_re;
      if (w_rd) r_rdata <= w_rdata_mux;
    end
  end

  assign bus.alarm_rdata = r_rdata;
  assign bus.alarm_ready = r_ready;
  assign bus.alarm_irq   = r_pend & r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_soc_rtc_alarm.sv
// ============================================================================
// tb_soc_rtc_alarm : directed scenarios for the RTC alarm unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_soc_rtc_alarm;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] rtc_count;
  logic         rtc_valid;
  int           checks   = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  soc_rtc_alarm_if #(.IO_MAP_WIDTH(W)) bus ();

  soc_rtc_alarm #(.IO_MAP_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rtc_count (rtc_count),
    .rtc_valid (rtc_valid),
    .bus       (bus)
  );

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.alarm_we = 1'b0; bus.alarm_re = 1'b0;
    bus.alarm_addr = 2'd0; bus.alarm_wdata = '0;
    rtc_valid = 1'b0; rtc_count = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
    bus.alarm_addr = a; bus.alarm_wdata = d; bus.alarm_we = 1'b1;
    @(posedge clk); #1;
    bus.alarm_we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [W-1:0] d);
    bus.alarm_addr = a; bus.alarm_re = 1'b1;
    @(posedge clk); #1;
    bus.alarm_re = 1'b0;
    d = bus.alarm_rdata;
  endtask

  task automatic step(input logic [W-1:0] c);
    rtc_count = c; rtc_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] d;
    apply_reset();
    checks++; if (bus.alarm_rdata !== '0) begin failures++; $display("FAIL reset_rdata got %0h want 0", bus.alarm_rdata); end
    checks++; if (bus.alarm_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %0b want 0", bus.alarm_ready); end
    checks++; if (bus.alarm_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %0b want 0", bus.alarm_irq); end
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], d);
      checks++; if (d !== '0) begin failures++; $display("FAIL reset_reg%0d got %0h want 0", a, d); end
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] d;
    logic         exp;
    apply_reset();
    bus_write(2'd1, 32'd100);
    bus_write(2'd0, 32'b101);
    for (int c = 95; c <= 105; c++) begin
      step(c);
      exp = (c >= 100);
      checks++; if (bus.alarm_irq !== exp) begin failures++; $display("FAIL oneshot_irq count=%0d got %0b want %0b", c, bus.alarm_irq, exp); end
    end
    rtc_valid = 1'b0;
    bus_read(2'd0, d);
    checks++; if (d !== 32'b100) begin failures++; $display("FAIL oneshot_ctrl got %0h want 4", d); end
    bus_read(2'd3, d);
    checks++; if (d !== 32'b01) begin failures++; $display("FAIL oneshot_status got %0h want 1", d); end
  endtask

  task automatic test_periodic();
    logic [W-1:0] d;
    logic         exp;
    logic         w1c;
    apply_reset();
    bus_write(2'd1, 32'd10);
    bus_write(2'd2, 32'd5);
    bus_write(2'd0, 32'b111);
    exp = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      w1c = (c == 12) || (c == 17) || (c == 22) || (c == 27);
      rtc_count = c; rtc_valid = 1'b1;
      if (w1c) begin bus.alarm_addr = 2'd3; bus.alarm_wdata = 32'd1; bus.alarm_we = 1'b1; end
      @(posedge clk); #1;
      bus.alarm_we = 1'b0;
      if (c >= 10 && (c % 5) == 0) exp = 1'b1;
      else if (w1c)                exp = 1'b0;
      checks++; if (bus.alarm_irq !== exp) begin failures++; $display("FAIL periodic_irq count=%0d got %0b want %0b", c, bus.alarm_irq, exp); end
    end
    rtc_valid = 1'b0;
    @(posedge clk); #1;
    bus_read(2'd1, d);
    checks++; if (d !== 32'd35) begin failures++; $display("FAIL periodic_cmp got %0d want 35", d); end
    bus_read(2'd3, d);
    checks++; if (d !== 32'b01) begin failures++; $display("FAIL periodic_status got %0h want 1", d); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] c;
    logic         exp;
    apply_reset();
    bus_write(2'd1, 32'h0000_0004);
    bus_write(2'd0, 32'b101);
    c = 32'hFFFF_FFFE;
    for (int i = 0; i < 9; i++) begin
      step(c);
      exp = (i >= 6);
      checks++; if (bus.alarm_irq !== exp) begin failures++; $display("FAIL wrap_irq count=%0h got %0b want %0b", c, bus.alarm_irq, exp); end
      c = c + 32'd1;
    end
    rtc_valid = 1'b0;
    bus_write(2'd3, 32'b11);
    bus_write(2'd1, 32'hFFFF_FFF0);
    rtc_count = 32'hFFFF_FFF8; rtc_valid = 1'b1;
    bus_write(2'd0, 32'b101);
    checks++; if (bus.alarm_irq !== 1'b0) begin failures++; $display("FAIL wrap_arm_edge got %0b want 0", bus.alarm_irq); end
    step(32'hFFFF_FFF8);
    checks++; if (bus.alarm_irq !== 1'b1) begin failures++; $display("FAIL wrap_immediate got %0b want 1", bus.alarm_irq); end
    rtc_valid = 1'b0;
  endtask

  task automatic test_masked();
    logic [W-1:0] d;
    apply_reset();
    bus_write(2'd1, 32'd4);
    bus_write(2'd0, 32'b001);
    step(32'd9);
    rtc_valid = 1'b0;
    checks++; if (bus.alarm_irq !== 1'b0) begin failures++; $display("FAIL masked_irq got %0b want 0", bus.alarm_irq); end
    bus_read(2'd3, d);
    checks++; if (d !== 32'b01) begin failures++; $display("FAIL masked_status got %0h want 1", d); end
    bus_write(2'd0, 32'b100);
    checks++; if (bus.alarm_irq !== 1'b1) begin failures++; $display("FAIL unmask_irq got %0b want 1", bus.alarm_irq); end
  endtask

  task automatic test_missed_race();
    logic [W-1:0] d;
    apply_reset();
    bus_write(2'd1, 32'd5);
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'b011);
    step(32'd10);
    step(32'd10);
    step(32'd10);
    rtc_valid = 1'b0;
    bus_read(2'd3, d);
    checks++; if (d !== 32'b11) begin failures++; $display("FAIL missed_status got %0h want 3", d); end
    bus_write(2'd3, 32'b11);
    bus_read(2'd3, d);
    checks++; if (d !== 32'b00) begin failures++; $display("FAIL w1c_clear got %0h want 0", d); end
    rtc_count = 32'd10; rtc_valid = 1'b1;
    bus_write(2'd3, 32'b11);
    rtc_valid = 1'b0;
    bus_read(2'd3, d);
    checks++; if (d !== 32'b01) begin failures++; $display("FAIL w1c_race got %0h want 1", d); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    apply_reset();
    bus.alarm_addr = 2'd1; bus.alarm_wdata = 32'h55;
    bus.alarm_we = 1'b1; bus.alarm_re = 1'b1;
    @(posedge clk); #1;
    bus.alarm_we = 1'b0; bus.alarm_re = 1'b0;
    checks++; if (bus.alarm_ready !== 1'b1) begin failures++; $display("FAIL wr_rd_ready got %0b want 1", bus.alarm_ready); end
    checks++; if (bus.alarm_rdata !== '0) begin failures++; $display("FAIL wr_rd_rdata got %0h want 0", bus.alarm_rdata); end
    @(posedge clk); #1;
    checks++; if (bus.alarm_ready !== 1'b0) begin failures++; $display("FAIL ready_single got %0b want 0", bus.alarm_ready); end
    bus_write(2'd2, 32'h33);
    bus.alarm_addr = 2'd1; bus.alarm_re = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.alarm_ready !== 1'b1 || bus.alarm_rdata !== 32'h55) begin failures++; $display("FAIL b2b_rd0 got ready=%0b data=%0h want ready=1 data=55", bus.alarm_ready, bus.alarm_rdata); end
    bus.alarm_addr = 2'd2;
    @(posedge clk); #1;
    checks++; if (bus.alarm_ready !== 1'b1 || bus.alarm_rdata !== 32'h33) begin failures++; $display("FAIL b2b_rd1 got ready=%0b data=%0h want ready=1 data=33", bus.alarm_ready, bus.alarm_rdata); end
    bus.alarm_re = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.alarm_ready !== 1'b0) begin failures++; $display("FAIL b2b_idle got %0b want 0", bus.alarm_ready); end
    bus_write(2'd0, 32'b101);
    rtc_count = 32'h100; rtc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.alarm_irq !== 1'b0) begin failures++; $display("FAIL novalid_irq got %0b want 0", bus.alarm_irq); end
    step(32'h100);
    rtc_valid = 1'b0;
    checks++; if (bus.alarm_irq !== 1'b1) begin failures++; $display("FAIL valid_irq got %0b want 1", bus.alarm_irq); end
    bus_read(2'd1, d);
    checks++; if (d !== 32'h55) begin failures++; $display("FAIL cmp_after got %0h want 55", d); end
  endtask

  task automatic test_reset_period0();
    logic [W-1:0] d;
    apply_reset();
    bus_write(2'd1, 32'd3);
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'b111);
    rtc_count = 32'd3; rtc_valid = 1'b1;
    bus.alarm_addr = 2'd2; bus.alarm_re = 1'b1;
    @(posedge clk); #1;
    bus.alarm_re = 1'b0; rtc_valid = 1'b0;
    checks++; if (bus.alarm_irq !== 1'b1 || bus.alarm_rdata !== 32'd2) begin failures++; $display("FAIL pre_reset got irq=%0b data=%0h want irq=1 data=2", bus.alarm_irq, bus.alarm_rdata); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.alarm_irq !== 1'b0 || bus.alarm_ready !== 1'b0 || bus.alarm_rdata !== '0) begin failures++; $display("FAIL async_reset got irq=%0b ready=%0b data=%0h want 0 0 0", bus.alarm_irq, bus.alarm_ready, bus.alarm_rdata); end
    #1 rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], d);
      checks++; if (d !== '0) begin failures++; $display("FAIL midreset_reg%0d got %0h want 0", a, d); end
    end
    bus_write(2'd1, 32'd3);
    bus_write(2'd0, 32'b011);
    step(32'd5);
    rtc_valid = 1'b0;
    bus_read(2'd0, d);
    checks++; if (d !== 32'b010) begin failures++; $display("FAIL period0_ctrl got %0h want 2", d); end
    bus_read(2'd1, d);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL period0_cmp got %0h want 3", d); end
    bus_read(2'd3, d);
    checks++; if (d !== 32'b01) begin failures++; $display("FAIL period0_status got %0h want 1", d); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_wrap();
    test_masked();
    test_missed_race();
    test_back_to_back();
    test_reset_period0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
